// File: rtl/leitor_caminho.sv
// leitor_caminho: walks the anterior (predecessor) memory from destino back to origem and streams each node visited
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   iniciar_in                start pulse (taken only when idle), latches origem_in/destino_in
//   lc_mem_rd_out/addr_out    anterior memory read port; mem_data_in returns one cycle after the strobe
//   lc_no_valid_out/no_out    node stream (destino first, origem last), lc_no_ultimo_out marks origem
//   no_ready_in               stream back-pressure
//   lc_ocupado_out            not idle; lc_pronto_out one-cycle end pulse; lc_erro_out broken path (sticky)
//   LEITOR_CAMINHO_COMPRIMENTO_EN adds lc_comprimento_out, hop count of the last finished trace
module leitor_caminho #(
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_PASSOS = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iniciar_in,
  input  logic [ADDR_WIDTH-1:0] origem_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  lc_mem_rd_out,
  output logic [ADDR_WIDTH-1:0] lc_mem_addr_out,
  input  logic [ADDR_WIDTH-1:0] mem_data_in,
  output logic                  lc_no_valid_out,
  output logic [ADDR_WIDTH-1:0] lc_no_out,
  output logic                  lc_no_ultimo_out,
  input  logic                  no_ready_in,
  output logic                  lc_ocupado_out,
  output logic                  lc_pronto_out,
  output logic                  lc_erro_out
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
  , output logic [ADDR_WIDTH:0] lc_comprimento_out
`endif
);
  typedef enum logic [2:0] {IDLE, ENVIAR, LER, ESPERA, FIM} estado_t;
  localparam logic [ADDR_WIDTH:0] ULTIMO_PASSO = (ADDR_WIDTH+1)'(MAX_PASSOS - 1);
  estado_t               estado;
  logic [ADDR_WIDTH-1:0] atual, origem;
  logic [ADDR_WIDTH:0]   passos;
  always_ff @(posedge clk) begin
    if (rst) begin
      estado           <= IDLE;
      atual            <= '0;
      origem           <= '0;
      passos           <= '0;
      lc_mem_rd_out    <= 1'b0;
      lc_mem_addr_out  <= '0;
      lc_no_valid_out  <= 1'b0;
      lc_no_out        <= '0;
      lc_no_ultimo_out <= 1'b0;
      lc_ocupado_out   <= 1'b0;
      lc_pronto_out    <= 1'b0;
      lc_erro_out      <= 1'b0;
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
      lc_comprimento_out <= '0;
`endif
    end else begin
      case (estado)
        IDLE: if (iniciar_in) begin
          origem           <= origem_in;
          atual            <= destino_in;
          passos           <= '0;
          lc_erro_out      <= 1'b0;
          lc_ocupado_out   <= 1'b1;
          lc_no_valid_out  <= 1'b1;
          lc_no_out        <= destino_in;
          lc_no_ultimo_out <= destino_in == origem_in;
          estado           <= ENVIAR;
        end
        // valid is always high here, so ready alone completes the handshake
        ENVIAR: if (no_ready_in) begin
          lc_no_valid_out  <= 1'b0;
          lc_no_ultimo_out <= 1'b0;
          if (atual == origem || passos == ULTIMO_PASSO) begin
            lc_erro_out   <= atual != origem;
            lc_pronto_out <= 1'b1;
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
            lc_comprimento_out <= (atual != origem) ? (ADDR_WIDTH+1)'(MAX_PASSOS) : passos;
`endif
            estado        <= FIM;
          end else begin
            lc_mem_rd_out   <= 1'b1;
            lc_mem_addr_out <= atual;
            estado          <= LER;
          end
        end
        LER: begin
          lc_mem_rd_out <= 1'b0;
          estado        <= ESPERA;
        end
        ESPERA: begin
          atual            <= mem_data_in;
          passos           <= (passos == '1) ? passos : passos + 1'b1;
          lc_no_valid_out  <= 1'b1;
          lc_no_out        <= mem_data_in;
          lc_no_ultimo_out <= mem_data_in == origem;
          estado           <= ENVIAR;
        end
        FIM: begin
          lc_pronto_out  <= 1'b0;
          lc_ocupado_out <= 1'b0;
          estado         <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_leitor_caminho.sv
// tb_leitor_caminho: directed checks of the path tracer on a 5-bit and a 3-bit instance
module tb_leitor_caminho;
  logic clk = 1'b0, rst = 1'b1;
  logic ini = 1'b0, ready = 1'b1;
  logic [4:0] org = '0, dst = '0, mem_a = '0, addr_a, no_a;
  logic rd_a, va, ult_a, ocup_a, pr_a, err_a;
  logic ini_b = 1'b0;
  logic [2:0] org_b = '0, dst_b = '0, mem_b = '0, addr_b, no_b;
  logic rd_b, vb, ult_b, ocup_b, pr_b, err_b;
  logic [4:0] anterior [32];
  logic [2:0] anterior_b [8];
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
  logic [5:0] comp_a;
  logic [3:0] comp_b;
`endif
  int n_vec = 0, n_bad = 0, cyc = 0;
  int beats_q[$], ult_q[$], rd_q[$], hs_cyc[$];
  int pronto_n = 0, pronto_cyc = 0, stall_bad = 0;
  int stall_no = 0, stall_ult = 0;
  bit stalled = 0;
  int hs_b = 0, ult_nb = 0, node_bad_b = 0, rd_nb = 0, rd_bad_b = 0, pronto_nb = 0;
  leitor_caminho #(.ADDR_WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .iniciar_in(ini), .origem_in(org), .destino_in(dst),
    .lc_mem_rd_out(rd_a), .lc_mem_addr_out(addr_a), .mem_data_in(mem_a),
    .lc_no_valid_out(va), .lc_no_out(no_a), .lc_no_ultimo_out(ult_a), .no_ready_in(ready),
    .lc_ocupado_out(ocup_a), .lc_pronto_out(pr_a), .lc_erro_out(err_a)
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
    , .lc_comprimento_out(comp_a)
`endif
  );
  leitor_caminho #(.ADDR_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst), .iniciar_in(ini_b), .origem_in(org_b), .destino_in(dst_b),
    .lc_mem_rd_out(rd_b), .lc_mem_addr_out(addr_b), .mem_data_in(mem_b),
    .lc_no_valid_out(vb), .lc_no_out(no_b), .lc_no_ultimo_out(ult_b), .no_ready_in(1'b1),
    .lc_ocupado_out(ocup_b), .lc_pronto_out(pr_b), .lc_erro_out(err_b)
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
    , .lc_comprimento_out(comp_b)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_a <= anterior[addr_a];
    mem_b <= anterior_b[addr_b];
  end
  always @(negedge clk) begin
    if (va && ready) begin
      beats_q.push_back(int'(no_a));
      ult_q.push_back(int'(ult_a));
      hs_cyc.push_back(cyc);
    end
    if (rd_a) rd_q.push_back(int'(addr_a));
    if (pr_a) begin
      pronto_n <= pronto_n + 1;
      pronto_cyc <= cyc;
    end
    if (stalled && !(va && int'(no_a) == stall_no && int'(ult_a) == stall_ult)) stall_bad <= stall_bad + 1;
    stalled <= va && !ready;
    stall_no <= int'(no_a);
    stall_ult <= int'(ult_a);
    if (vb) begin
      hs_b <= hs_b + 1;
      if (ult_b) ult_nb <= ult_nb + 1;
      if (no_b != 3'd4) node_bad_b <= node_bad_b + 1;
    end
    if (rd_b) begin
      rd_nb <= rd_nb + 1;
      if (addr_b != 3'd4) rd_bad_b <= rd_bad_b + 1;
    end
    if (pr_b) pronto_nb <= pronto_nb + 1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start_a(input logic [4:0] o, input logic [4:0] d);
    org = o;
    dst = d;
    ini = 1'b1;
    step();
    ini = 1'b0;
  endtask
  task automatic wait_pronto(input string tag, input bit toggle, input bit use_b);
    logic [3:0] pat = 4'b1001;
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (toggle) ready = pat[i % 4];
      step();
      seen = use_b ? pr_b : pr_a;
    end
    ready = 1'b1;
    chk(tag, int'(seen), 1);
    step();
  endtask
  task automatic chk_path(input string tag, input int b, input int r, input int p0);
    chk({tag, " beats"}, beats_q.size() - b, 4);
    chk({tag, " beat0"}, beats_q[b], 7);
    chk({tag, " beat1"}, beats_q[b+1], 3);
    chk({tag, " beat2"}, beats_q[b+2], 1);
    chk({tag, " beat3"}, beats_q[b+3], 0);
    chk({tag, " ult012"}, ult_q[b] + ult_q[b+1] + ult_q[b+2], 0);
    chk({tag, " ult3"}, ult_q[b+3], 1);
    chk({tag, " reads"}, rd_q.size() - r, 3);
    chk({tag, " rd0"}, rd_q[r], 7);
    chk({tag, " rd1"}, rd_q[r+1], 3);
    chk({tag, " rd2"}, rd_q[r+2], 1);
    chk({tag, " pronto n"}, pronto_n - p0, 1);
    chk({tag, " pronto lat"}, pronto_cyc - hs_cyc[b+3], 1);
    chk({tag, " erro"}, int'(err_a), 0);
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
    chk({tag, " comp"}, int'(comp_a), 3);
`endif
  endtask
  initial begin
    int b, r, p;
    bit seen;
    foreach (anterior[i]) anterior[i] = '0;
    foreach (anterior_b[i]) anterior_b[i] = '0;
    anterior[7] = 5'd3;
    anterior[3] = 5'd1;
    anterior[1] = 5'd0;
    anterior_b[4] = 3'd4;
    step();
    step();
    chk("rst valid", int'(va), 0);
    chk("rst outs", int'({rd_a, ult_a, ocup_a, pr_a, err_a}), 0);
    chk("rst no/addr", int'({no_a, addr_a}), 0);
    rst = 1'b0;
    step();
    b = beats_q.size(); r = rd_q.size(); p = pronto_n;
    start_a(5'd0, 5'd7);
    chk("t1 first valid", int'(va), 1);
    chk("t1 first no", int'(no_a), 7);
    chk("t1 ocupado", int'(ocup_a), 1);
    wait_pronto("t1 done", 0, 0);
    chk("t1 pronto 1cyc", int'(pr_a), 0);
    chk("t1 idle", int'(ocup_a), 0);
    chk_path("t1", b, r, p);
    chk("t1 hop rate", hs_cyc[b+1] - hs_cyc[b], 3);
    b = beats_q.size(); r = rd_q.size(); p = pronto_n;
    start_a(5'd5, 5'd5);
    chk("t2 ult live", int'(ult_a), 1);
    wait_pronto("t2 done", 0, 0);
    chk("t2 beats", beats_q.size() - b, 1);
    chk("t2 beat", beats_q[b], 5);
    chk("t2 ult", ult_q[b], 1);
    chk("t2 reads", rd_q.size() - r, 0);
    chk("t2 pronto", pronto_n - p, 1);
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
    chk("t2 comp", int'(comp_a), 0);
`endif
    b = beats_q.size(); r = rd_q.size(); p = pronto_n;
    start_a(5'd0, 5'd7);
    wait_pronto("t3 done", 1, 0);
    chk_path("t3", b, r, p);
    chk("t3 stall stable", stall_bad, 0);
    org_b = 3'd0;
    dst_b = 3'd4;
    ini_b = 1'b1;
    step();
    ini_b = 1'b0;
    wait_pronto("t4 done", 0, 1);
    chk("t4 beats", hs_b, 8);
    chk("t4 nodes", node_bad_b, 0);
    chk("t4 ult", ult_nb, 0);
    chk("t4 reads", rd_nb, 7);
    chk("t4 rd addr", rd_bad_b, 0);
    chk("t4 pronto", pronto_nb, 1);
    chk("t4 erro", int'(err_b), 1);
`ifdef LEITOR_CAMINHO_COMPRIMENTO_EN
    chk("t4 comp", int'(comp_b), 8);
`endif
    step();
    step();
    chk("t4 erro held", int'(err_b), 1);
    org_b = 3'd2;
    dst_b = 3'd2;
    ini_b = 1'b1;
    step();
    ini_b = 1'b0;
    chk("t4 erro cleared", int'(err_b), 0);
    wait_pronto("t4b done", 0, 1);
    start_a(5'd0, 5'd7);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = rd_a;
    end
    chk("t5 reached LER", int'(seen), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5 rst outs", int'({va, rd_a, ult_a, ocup_a, pr_a, err_a}), 0);
    chk("t5 rst no/addr", int'({no_a, addr_a}), 0);
    b = beats_q.size(); r = rd_q.size(); p = pronto_n;
    start_a(5'd0, 5'd3);
    wait_pronto("t5 done", 0, 0);
    chk("t5 beats", beats_q.size() - b, 3);
    chk("t5 beat0", beats_q[b], 3);
    chk("t5 beat1", beats_q[b+1], 1);
    chk("t5 beat2", beats_q[b+2], 0);
    chk("t5 reads", rd_q.size() - r, 2);
    b = beats_q.size(); r = rd_q.size(); p = pronto_n;
    start_a(5'd0, 5'd7);
    step();
    org = 5'd2;
    dst = 5'd2;
    ini = 1'b1;
    step();
    ini = 1'b0;
    wait_pronto("t6 done", 0, 0);
    chk_path("t6", b, r, p);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
